// File: rtl/ship_motion_pkg.sv
// ============================================================================
// Module      : ship_motion_pkg
// Description : Shared definitions for the ship kinematics stage.
//               - Bit positions of the 6-bit heading code
//                 {sx, mx[1:0], sy, my[1:0]}
//               - Velocity register width
//               - Default screen size
//               - FSM state type
//               - Saturating velocity adder
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ship_motion_pkg;

   // Heading code layout; the direction rotator and renderer use the same layout.
   localparam int DIR_W     = 6;
   localparam int DIR_SX    = 5;
   localparam int DIR_MX_HI = 4;
   localparam int DIR_MX_LO = 3;
   localparam int DIR_SY    = 2;
   localparam int DIR_MY_HI = 1;
   localparam int DIR_MY_LO = 0;

   // Velocity registers are 5-bit two's complement.
   localparam int VEL_W = 5;

   localparam int DEF_SCREEN_W = 160;
   localparam int DEF_SCREEN_H = 120;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_VEL  = 2'd1,
      ST_POS  = 2'd2
   } motionState_t;

   // Adds two velocities one bit wider than the operands, so the sum cannot overflow.
   // The result is then clamped to +-limit.
   function automatic logic signed [VEL_W-1:0] satAdd(
      input logic signed [VEL_W-1:0] a,
      input logic signed [VEL_W-1:0] b,
      input logic signed [VEL_W:0]   limit
   );
      logic signed [VEL_W:0] sum;
      sum = $signed({a[VEL_W-1], a}) + $signed({b[VEL_W-1], b});
      if (sum > limit) begin
         sum = limit;
      end else if (sum < -limit) begin
         sum = -limit;
      end
      return sum[VEL_W-1:0];
   endfunction

endpackage

`default_nettype wire

// File: rtl/ship_motion_dir_axis_decode.sv
// ============================================================================
// Module      : dir_axis_decode
// Description : Converts one axis of the heading code (a sign bit plus a 2-bit
//               magnitude) into a 5-bit two's-complement step.
//               A negative sign with zero magnitude decodes to 0.
// Ports       : negative  in  1      sign bit (1 = negative)
//               mag       in  2      magnitude 0..3
//               value     out VEL_W  signed step
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dir_axis_decode
   import ship_motion_pkg::*;
(
   input  logic                    negative,
   input  logic [1:0]              mag,
   output logic signed [VEL_W-1:0] value
);

   logic signed [VEL_W-1:0] magExt;

   assign magExt = {{(VEL_W-2){1'b0}}, mag};
   assign value  = negative ? -magExt : magExt;

endmodule

`default_nettype wire

// File: rtl/ship_motion.sv
// ============================================================================
// Module      : ship_motion
// Description : Ship kinematics stage. Each move tick runs a three-step sequence:
//                 IDLE -> VEL -> POS -> IDLE
//               - IDLE latches the heading and thrust.
//               - VEL integrates the heading into velocity, with saturation.
//               - POS integrates velocity into position, wrapping at the
//                 screen edges.
//               respawn overrides everything.
//               Optional macro SHIP_DRAG_EN: on every DRAG_PERIOD-th processed
//               tick without thrust, each velocity axis decays one step
//               toward zero.
// Ports       : clock         in   1     system clock (posedge)
//               resetn        in   1     asynchronous active-low reset
//               move_tick     in   1     one-cycle pulse: start a motion update
//               direction     in   6     heading {sx,mx[1:0],sy,my[1:0]}, y+ = up
//               thrust        in   1     sampled with move_tick
//               respawn       in   1     reload start position, zero velocity
//               ship_x        out  X_W   current x
//               ship_y        out  Y_W   current y (0 = top row)
//               vel_x         out  5     signed x velocity
//               vel_y         out  5     signed y velocity, screen-up positive
//               update_done   out  1     one-cycle pulse: new position valid
//               tick_overrun  out  1     sticky: a move_tick was dropped
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ship_motion
   import ship_motion_pkg::*;
#(
   parameter int SCREEN_W = DEF_SCREEN_W,
   parameter int SCREEN_H = DEF_SCREEN_H,
   parameter int X_W      = 8,
   parameter int Y_W      = 7,
   parameter int MAX_VEL  = 7,
   parameter int START_X  = 80,
   parameter int START_Y  = 60
`ifdef SHIP_DRAG_EN
   ,
   parameter int DRAG_PERIOD = 8
`endif
)(
   input  logic                    clock,
   input  logic                    resetn,
   input  logic                    move_tick,
   input  logic [DIR_W-1:0]        direction,
   input  logic                    thrust,
   input  logic                    respawn,
   output logic [X_W-1:0]          ship_x,
   output logic [Y_W-1:0]          ship_y,
   output logic signed [VEL_W-1:0] vel_x,
   output logic signed [VEL_W-1:0] vel_y,
   output logic                    update_done,
   output logic                    tick_overrun
);

   localparam logic signed [VEL_W:0] VEL_LIMIT    = (VEL_W+1)'(MAX_VEL);
   localparam logic signed [X_W+1:0] SCREEN_W_EXT = (X_W+2)'(SCREEN_W);
   localparam logic signed [Y_W+1:0] SCREEN_H_EXT = (Y_W+2)'(SCREEN_H);
   localparam logic [X_W-1:0]        SCREEN_W_N   = X_W'(SCREEN_W);
   localparam logic [Y_W-1:0]        SCREEN_H_N   = Y_W'(SCREEN_H);
   localparam logic [X_W-1:0]        START_X_N    = X_W'(START_X);
   localparam logic [Y_W-1:0]        START_Y_N    = Y_W'(START_Y);

   motionState_t            state;
   motionState_t            stateNext;
   logic                    latchTick;
   logic                    dropTick;
   logic [DIR_W-1:0]        dirQ;
   logic                    thrustQ;
   logic signed [VEL_W-1:0] decX;
   logic signed [VEL_W-1:0] decY;
   logic signed [VEL_W-1:0] velXNext;
   logic signed [VEL_W-1:0] velYNext;
   logic signed [X_W+1:0]   sumX;
   logic signed [Y_W+1:0]   sumY;
   logic [X_W-1:0]          shipXNext;
   logic [Y_W-1:0]          shipYNext;

   dir_axis_decode u_decodeX (
      .negative (dirQ[DIR_SX]),
      .mag      (dirQ[DIR_MX_HI:DIR_MX_LO]),
      .value    (decX)
   );

   dir_axis_decode u_decodeY (
      .negative (dirQ[DIR_SY]),
      .mag      (dirQ[DIR_MY_HI:DIR_MY_LO]),
      .value    (decY)
   );

   // ---------------------------------------------------------------- FSM
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state <= ST_IDLE;
      end else begin
         state <= stateNext;
      end
   end

   always_comb begin
      stateNext = state;
      latchTick = 1'b0;
      dropTick  = 1'b0;
      case (state)
         ST_IDLE: begin
            if (move_tick) begin
               latchTick = 1'b1;
               stateNext = ST_VEL;
            end
         end
         ST_VEL: begin
            dropTick  = move_tick;
            stateNext = ST_POS;
         end
         ST_POS: begin
            dropTick  = move_tick;
            stateNext = ST_IDLE;
         end
         default: begin
            dropTick  = move_tick;
            stateNext = ST_IDLE;
         end
      endcase
      // A tick arriving together with respawn is swallowed silently.
      if (respawn) begin
         stateNext = ST_IDLE;
         latchTick = 1'b0;
         dropTick  = 1'b0;
      end
   end

   // ---------------------------------------------------------------- drag
`ifdef SHIP_DRAG_EN
   localparam logic [2:0] DRAG_LAST = 3'(DRAG_PERIOD - 1);

   logic [2:0] dragCount;
   logic       dragHit;

   assign dragHit = (dragCount == DRAG_LAST) && !thrustQ;

   function automatic logic signed [VEL_W-1:0] towardZero(input logic signed [VEL_W-1:0] v);
      if (v[VEL_W-1]) begin
         return v + VEL_W'(1);
      end else if (v != '0) begin
         return v - VEL_W'(1);
      end
      return v;
   endfunction
`endif

   // ---------------------------------------------------------------- velocity
   always_comb begin
      velXNext = vel_x;
      velYNext = vel_y;
      if (thrustQ) begin
         velXNext = satAdd(vel_x, decX, VEL_LIMIT);
         velYNext = satAdd(vel_y, decY, VEL_LIMIT);
      end
`ifdef SHIP_DRAG_EN
      else if (dragHit) begin
         velXNext = towardZero(vel_x);
         velYNext = towardZero(vel_y);
      end
`endif
   end

   // ---------------------------------------------------------------- position
   // Positive y velocity means "up", and row 0 is the top of the screen,
   // so y moves opposite to vel_y.
   // Because |vel| < screen size, a single add or subtract brings the sum
   // back into range. The correction is done on the low bits only, which is
   // exact modulo 2^W.
   always_comb begin
      sumX = $signed({2'b00, ship_x}) + $signed({{(X_W+2-VEL_W){vel_x[VEL_W-1]}}, vel_x});
      sumY = $signed({2'b00, ship_y}) - $signed({{(Y_W+2-VEL_W){vel_y[VEL_W-1]}}, vel_y});

      shipXNext = sumX[X_W-1:0];
      if (sumX[X_W+1]) begin
         shipXNext = sumX[X_W-1:0] + SCREEN_W_N;
      end else if (sumX >= SCREEN_W_EXT) begin
         shipXNext = sumX[X_W-1:0] - SCREEN_W_N;
      end

      shipYNext = sumY[Y_W-1:0];
      if (sumY[Y_W+1]) begin
         shipYNext = sumY[Y_W-1:0] + SCREEN_H_N;
      end else if (sumY >= SCREEN_H_EXT) begin
         shipYNext = sumY[Y_W-1:0] - SCREEN_H_N;
      end
   end

   // ---------------------------------------------------------------- datapath
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         ship_x       <= START_X_N;
         ship_y       <= START_Y_N;
         vel_x        <= '0;
         vel_y        <= '0;
         dirQ         <= '0;
         thrustQ      <= 1'b0;
         update_done  <= 1'b0;
         tick_overrun <= 1'b0;
`ifdef SHIP_DRAG_EN
         dragCount    <= '0;
`endif
      end else if (respawn) begin
         ship_x       <= START_X_N;
         ship_y       <= START_Y_N;
         vel_x        <= '0;
         vel_y        <= '0;
         update_done  <= 1'b0;
`ifdef SHIP_DRAG_EN
         dragCount    <= '0;
`endif
      end else begin
         update_done <= (state == ST_POS);
         if (dropTick) begin
            tick_overrun <= 1'b1;
         end
         if (latchTick) begin
            dirQ    <= direction;
            thrustQ <= thrust;
         end
         if (state == ST_VEL) begin
            vel_x <= velXNext;
            vel_y <= velYNext;
`ifdef SHIP_DRAG_EN
            dragCount <= (dragCount == DRAG_LAST) ? 3'd0 : dragCount + 3'd1;
`endif
         end
         if (state == ST_POS) begin
            ship_x <= shipXNext;
            ship_y <= shipYNext;
         end
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_ship_motion.sv
// ============================================================================
// Module      : tb_ship_motion
// Description : Self-checking bench for ship_motion (default build, drag off).
//               - Directed vector table
//               - Hand-written corner sequences
//               - Randomized ticks checked against a modular-arithmetic
//                 reference model
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ship_motion;

   logic              clock        = 1'b0;
   logic              resetn       = 1'b0;
   logic              move_tick    = 1'b0;
   logic [5:0]        direction    = 6'd0;
   logic              thrust       = 1'b0;
   logic              respawn      = 1'b0;
   logic [7:0]        ship_x;
   logic [6:0]        ship_y;
   logic signed [4:0] vel_x;
   logic signed [4:0] vel_y;
   logic              update_done;
   logic              tick_overrun;

   int checks = 0;
   int errors = 0;

   // Reference model state
   int mX, mY, mVx, mVy;

   typedef struct {
      logic [5:0] dir;
      logic       thr;
      int         ex;
      int         ey;
      int         evx;
      int         evy;
   } vec_t;

   ship_motion dut (
      .clock        (clock),
      .resetn       (resetn),
      .move_tick    (move_tick),
      .direction    (direction),
      .thrust       (thrust),
      .respawn      (respawn),
      .ship_x       (ship_x),
      .ship_y       (ship_y),
      .vel_x        (vel_x),
      .vel_y        (vel_y),
      .update_done  (update_done),
      .tick_overrun (tick_overrun)
   );

   always #5 clock = ~clock;

   initial begin
      #5000000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d", name, act, exp);
      end
   endtask

   function automatic int decodeAxis(input int s, input int m);
      return (s != 0) ? -m : m;
   endfunction

   function automatic int clampVel(input int v);
      if (v > 7)  return 7;
      if (v < -7) return -7;
      return v;
   endfunction

   function automatic int wrapMod(input int v, input int n);
      return ((v % n) + n) % n;
   endfunction

   task automatic modelReset();
      mX = 80; mY = 60; mVx = 0; mVy = 0;
   endtask

   task automatic modelTick(input logic [5:0] d, input logic t);
      if (t) begin
         mVx = clampVel(mVx + decodeAxis(int'(d[5]), int'(d[4:3])));
         mVy = clampVel(mVy + decodeAxis(int'(d[2]), int'(d[1:0])));
      end
      mX = wrapMod(mX + mVx, 160);
      mY = wrapMod(mY - mVy, 120);
   endtask

   task automatic checkModel(input string tag);
      check({tag, "_x"},  int'(ship_x), mX);
      check({tag, "_y"},  int'(ship_y), mY);
      check({tag, "_vx"}, int'(vel_x),  mVx);
      check({tag, "_vy"}, int'(vel_y),  mVy);
   endtask

   // Runs one full tick. The task returns one time unit after E2, when the
   // done pulse is expected. The inputs are scrambled right after E0, so a
   // design that fails to latch the heading and thrust gets caught.
   task automatic doTick(input logic [5:0] d, input logic t);
      @(posedge clock); #1;
      check("done_idle", int'(update_done), 0);
      direction = d; thrust = t; move_tick = 1'b1;
      @(posedge clock); #1;
      move_tick = 1'b0; direction = ~d; thrust = ~t;
      @(posedge clock); #1;
      check("done_early", int'(update_done), 0);
      @(posedge clock); #1;
      check("done_pulse", int'(update_done), 1);
      modelTick(d, t);
   endtask

   task automatic doRespawn();
      @(posedge clock); #1;
      respawn = 1'b1;
      @(posedge clock); #1;
      respawn = 1'b0;
      modelReset();
   endtask

   initial begin
      vec_t tbl [8];
      int   pulses;

      tbl[0] = '{6'b001011, 1'b1,  81, 57, 1,  3};
      tbl[1] = '{6'b011000, 1'b1,  85, 54, 4,  3};
      tbl[2] = '{6'b011000, 1'b1,  92, 51, 7,  3};
      tbl[3] = '{6'b011000, 1'b1,  99, 48, 7,  3};
      tbl[4] = '{6'b111111, 1'b1, 103, 48, 4,  0};
      tbl[5] = '{6'b100100, 1'b1, 107, 48, 4,  0};
      tbl[6] = '{6'b101111, 1'b0, 111, 48, 4,  0};
      tbl[7] = '{6'b000111, 1'b1, 115, 51, 4, -3};

      // Reset state
      repeat (3) @(posedge clock);
      #1;
      check("rst_x",       int'(ship_x),       80);
      check("rst_y",       int'(ship_y),       60);
      check("rst_vx",      int'(vel_x),        0);
      check("rst_vy",      int'(vel_y),        0);
      check("rst_done",    int'(update_done),  0);
      check("rst_overrun", int'(tick_overrun), 0);
      resetn = 1'b1;
      modelReset();

      // Directed table
      for (int i = 0; i < 8; i++) begin
         doTick(tbl[i].dir, tbl[i].thr);
         check("tbl_x",  int'(ship_x), tbl[i].ex);
         check("tbl_y",  int'(ship_y), tbl[i].ey);
         check("tbl_vx", int'(vel_x),  tbl[i].evx);
         check("tbl_vy", int'(vel_y),  tbl[i].evy);
      end

      // Saturation: repeated +3 thrust on x must stop at +7
      doRespawn();
      for (int i = 0; i < 10; i++) begin
         doTick(6'b011000, 1'b1);
         check("sat_vx", int'(vel_x), (3 * (i + 1) > 7) ? 7 : 3 * (i + 1));
         checkModel("sat");
      end

      // Wrap across both edges. With vel (+3,+3):
      //  - x crosses 159 -> 0
      //  - y crosses 0 -> 119
      doRespawn();
      doTick(6'b011011, 1'b1);
      checkModel("wrap0");
      for (int n = 2; n <= 60; n++) begin
         doTick(6'b101010, 1'b0);
         check("wrap_x", int'(ship_x), wrapMod(80 + 3 * n, 160));
         check("wrap_y", int'(ship_y), wrapMod(60 - 3 * n, 120));
      end
      checkModel("wrapEnd");

      // Randomized ticks against the model
      doRespawn();
      for (int i = 0; i < 300; i++) begin
         logic [5:0] rd;
         logic       rt;
         rd = 6'($urandom_range(0, 63));
         rt = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 19) == 0) begin
            doRespawn();
            checkModel("rnd_resp");
         end
         repeat ($urandom_range(0, 2)) @(posedge clock);
         doTick(rd, rt);
         checkModel("rnd");
      end
      check("rnd_overrun", int'(tick_overrun), 0);

      // Respawn during POS, with a coincident move_tick
      doTick(6'b011011, 1'b1);
      @(posedge clock); #1;
      direction = 6'b001001; thrust = 1'b1; move_tick = 1'b1;
      @(posedge clock); #1;            // E0 seen
      move_tick = 1'b0;
      @(posedge clock); #1;            // E1: now in POS
      respawn = 1'b1; move_tick = 1'b1;
      @(posedge clock); #1;            // E2: respawn wins
      respawn = 1'b0; move_tick = 1'b0;
      modelReset();
      check("resp_done", int'(update_done), 0);
      checkModel("resp");
      pulses = 0;
      for (int k = 0; k < 6; k++) begin
         if (update_done) pulses++;
         @(posedge clock); #1;
      end
      check("resp_pulses",  pulses,             0);
      check("resp_overrun", int'(tick_overrun), 0);
      checkModel("resp_hold");
      doTick(6'b010001, 1'b1);
      checkModel("resp_after");

      // Overrun: ticks at E0 and E1 -> one update only, sticky flag set
      @(posedge clock); #1;
      direction = 6'b001010; thrust = 1'b1; move_tick = 1'b1;
      @(posedge clock); #1;            // E0
      @(posedge clock); #1;            // E1 (second tick dropped)
      move_tick = 1'b0;
      modelTick(6'b001010, 1'b1);
      pulses = 0;
      for (int k = 0; k < 8; k++) begin
         if (update_done) pulses++;
         @(posedge clock); #1;
      end
      check("ovr_pulses", pulses,             1);
      check("ovr_flag",   int'(tick_overrun), 1);
      checkModel("ovr");

      // Asynchronous reset clears the sticky flag without needing a clock edge
      #2;
      resetn = 1'b0;
      #1;
      check("arst_overrun", int'(tick_overrun), 0);
      check("arst_x",       int'(ship_x),       80);
      check("arst_vx",      int'(vel_x),        0);
      @(posedge clock); #1;
      resetn = 1'b1;
      modelReset();
      doTick(6'b001011, 1'b1);
      check("post_x", int'(ship_x), 81);
      check("post_y", int'(ship_y), 57);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
